// File: rtl/ad4003_sdo_reader.sv
// Captures the AD4003 SDO lanes during each read window and commits one parallel
// multi-channel frame per conversion, with valid/ready handshake and error counters.
module ad4003_sdo_reader #(
    parameter int unsigned N_CH   = 48,
    parameter int unsigned DATA_W = 18
) (
    input  logic                   adc_read_clk,
    input  logic                   rst,
    input  logic                   reader_en_sync,
    input  logic [N_CH-1:0]        adc_sdo,
    input  logic                   data_ready,
    output logic [N_CH*DATA_W-1:0] adc_data,
    output logic                   data_valid,
    output logic [15:0]            frame_seq,
    output logic [15:0]            frame_err_cnt,
    output logic [15:0]            overrun_cnt
);

    localparam logic [5:0] BitCntMax = 6'd63;
    localparam logic [5:0] FrameBits = 6'(DATA_W);

    logic                   en_dly_q;
    logic                   armed_q;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic [N_CH*DATA_W-1:0] sh_q, sh_d;

    logic capture;
    logic win_end;
    logic commit;
    logic drop;
    logic accept;

    always_comb begin
        capture = armed_q && reader_en_sync;
        win_end = armed_q && en_dly_q && !reader_en_sync;
        commit  = win_end && (bit_cnt_q == FrameBits);
        drop    = win_end && (bit_cnt_q != FrameBits);
        accept  = data_valid && data_ready;

        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        if (capture) begin
            if (!en_dly_q) begin
                bit_cnt_d = 6'd1;
            end else if (bit_cnt_q != BitCntMax) begin
                bit_cnt_d = bit_cnt_q + 6'd1;
            end
            // Lane layout of sh_q matches adc_data so a commit is a straight copy.
            for (int c = 0; c < N_CH; c++) begin
                sh_d[c*DATA_W +: DATA_W] = {sh_q[c*DATA_W +: DATA_W-1], adc_sdo[c]};
            end
        end
    end

    always_ff @(posedge adc_read_clk) begin
        if (rst) begin
            en_dly_q  <= 1'b0;
            armed_q   <= 1'b0;
            bit_cnt_q <= '0;
            sh_q      <= '0;
        end else begin
            en_dly_q  <= reader_en_sync;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            // Arm only after an idle cycle so a window cut by reset is never judged.
            if (!reader_en_sync) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge adc_read_clk) begin
        if (rst) begin
            adc_data    <= '0;
            data_valid  <= 1'b0;
            frame_seq   <= '0;
            overrun_cnt <= '0;
        end else if (commit) begin
            adc_data   <= sh_q;
            data_valid <= 1'b1;
            frame_seq  <= frame_seq + 16'd1;
            if (data_valid && !data_ready && (overrun_cnt != 16'hFFFF)) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end
        end else if (accept) begin
            data_valid <= 1'b0;
        end
    end

    always_ff @(posedge adc_read_clk) begin
        if (rst) begin
            frame_err_cnt <= '0;
        end else if (drop && (frame_err_cnt != 16'hFFFF)) begin
            frame_err_cnt <= frame_err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ad4003_sdo_reader.sv
// Bench for ad4003_sdo_reader: vector table of windows plus hand sequences for
// backpressure, accept-on-commit, reset and counter limits; frames are scoreboarded.
module tb_ad4003_sdo_reader;

    localparam int unsigned N_CH   = 48;
    localparam int unsigned DATA_W = 18;
    localparam int unsigned FW     = N_CH * DATA_W;

    logic              adc_read_clk = 1'b0;
    logic              rst;
    logic              reader_en_sync;
    logic [N_CH-1:0]   adc_sdo;
    logic              data_ready;
    logic [FW-1:0]     adc_data;
    logic              data_valid;
    logic [15:0]       frame_seq;
    logic [15:0]       frame_err_cnt;
    logic [15:0]       overrun_cnt;

    ad4003_sdo_reader #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W)
    ) dut (
        .adc_read_clk   (adc_read_clk),
        .rst            (rst),
        .reader_en_sync (reader_en_sync),
        .adc_sdo        (adc_sdo),
        .data_ready     (data_ready),
        .adc_data       (adc_data),
        .data_valid     (data_valid),
        .frame_seq      (frame_seq),
        .frame_err_cnt  (frame_err_cnt),
        .overrun_cnt    (overrun_cnt)
    );

    always #5 adc_read_clk = ~adc_read_clk;

    typedef struct {
        logic [FW-1:0] data;
        logic [15:0]   seq;
    } exp_t;

    typedef struct {
        int                len;
        logic [DATA_W-1:0] c0;
        logic [DATA_W-1:0] cl;
        logic [DATA_W-1:0] co;
        bit                ok;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] m_seq;
    logic [15:0] m_err;
    logic [15:0] m_ovr;

    function automatic logic [FW-1:0] make_frame(input logic [DATA_W-1:0] c0,
                                                 input logic [DATA_W-1:0] cl,
                                                 input logic [DATA_W-1:0] co);
        logic [FW-1:0] f;
        for (int c = 0; c < N_CH; c++) begin
            f[c*DATA_W +: DATA_W] = (c == 0) ? c0 : ((c == N_CH - 1) ? cl : co);
        end
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic chk_frame(input string name, input logic [FW-1:0] act,
                             input logic [FW-1:0] req);
        int lane;
        lane = -1;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (act[c*DATA_W +: DATA_W] !== req[c*DATA_W +: DATA_W]) lane = c;
        end
        n_checks++;
        if (lane < 0) n_pass++;
        else $display("FAIL %s: lane %0d got 0x%05h, required 0x%05h", name, lane,
                      act[lane*DATA_W +: DATA_W], req[lane*DATA_W +: DATA_W]);
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so the negedge view is
    // exactly what the DUT samples for the handshake.
    task automatic monitor();
        exp_t e;
        if (data_valid && data_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_frame: got accepted frame seq 0x%0h, required none",
                         frame_seq);
            end else begin
                e = sb.pop_front();
                chk_frame("frame_data", adc_data, e.data);
                chk("frame_seq_at_accept", {16'd0, frame_seq}, {16'd0, e.seq});
            end
        end
    endtask

    task automatic tick();
        @(negedge adc_read_clk);
        monitor();
        @(posedge adc_read_clk);
        #1;
    endtask

    task automatic set_lanes(input logic [DATA_W-1:0] c0, input logic [DATA_W-1:0] cl,
                             input logic [DATA_W-1:0] co, input int i);
        logic [FW-1:0] f;
        logic [DATA_W-1:0] code;
        f = make_frame(c0, cl, co);
        for (int c = 0; c < N_CH; c++) begin
            code = f[c*DATA_W +: DATA_W];
            adc_sdo[c] = (i < int'(DATA_W)) ? code[DATA_W-1-i] : 1'b0;
        end
    endtask

    task automatic push_expected(input logic [FW-1:0] f);
        exp_t e;
        m_seq = m_seq + 16'd1;
        if (!data_ready && sb.size() > 0) begin
            void'(sb.pop_back());
            if (m_ovr != 16'hFFFF) m_ovr = m_ovr + 16'd1;
        end
        e.data = f;
        e.seq  = m_seq;
        sb.push_back(e);
    endtask

    task automatic drive_window(input int len, input logic [DATA_W-1:0] c0,
                                input logic [DATA_W-1:0] cl, input logic [DATA_W-1:0] co,
                                input bit ok, input logic end_ready);
        for (int i = 0; i < len; i++) begin
            reader_en_sync = 1'b1;
            set_lanes(c0, cl, co, i);
            tick();
        end
        reader_en_sync = 1'b0;
        adc_sdo        = '0;
        data_ready     = end_ready;
        if (ok) push_expected(make_frame(c0, cl, co));
        else if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        tick();
    endtask

    task automatic clear_model();
        sb.delete();
        m_seq = '0;
        m_err = '0;
        m_ovr = '0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        reader_en_sync = 1'b0;
        adc_sdo        = '0;
        data_ready     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_model();
        tick();
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_frame_seq"}, {16'd0, frame_seq}, {16'd0, m_seq});
        chk({tag, "_frame_err_cnt"}, {16'd0, frame_err_cnt}, {16'd0, m_err});
        chk({tag, "_overrun_cnt"}, {16'd0, overrun_cnt}, {16'd0, m_ovr});
    endtask

    task automatic check_zero(input string tag);
        chk_frame({tag, "_adc_data"}, adc_data, '0);
        chk({tag, "_data_valid"}, {31'd0, data_valid}, 32'd0);
        chk({tag, "_frame_seq"}, {16'd0, frame_seq}, 32'd0);
        chk({tag, "_frame_err_cnt"}, {16'd0, frame_err_cnt}, 32'd0);
        chk({tag, "_overrun_cnt"}, {16'd0, overrun_cnt}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{18, 18'h2AAAA, 18'h3FFFF, 18'h00001, 1'b1};
        vecs[1] = '{17, 18'h15555, 18'h3FFFF, 18'h00001, 1'b0};
        vecs[2] = '{19, 18'h15555, 18'h3FFFF, 18'h00001, 1'b0};
        vecs[3] = '{18, 18'h20000, 18'h1FFFF, 18'h12345, 1'b1};
        vecs[4] = '{1,  18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 1'b0};
        vecs[5] = '{82, 18'h0F0F0, 18'h3FFFF, 18'h00001, 1'b0};
        vecs[6] = '{18, 18'h00000, 18'h3FFFF, 18'h35555, 1'b1};
        vecs[7] = '{18, 18'h3C3C3, 18'h00003, 18'h2DB6D, 1'b1};

        do_reset();
        check_zero("reset");

        data_ready = 1'b1;
        foreach (vecs[v]) begin
            drive_window(vecs[v].len, vecs[v].c0, vecs[v].cl, vecs[v].co, vecs[v].ok, 1'b1);
            chk($sformatf("vec%0d_valid", v), {31'd0, data_valid}, {31'd0, vecs[v].ok});
            check_counters($sformatf("vec%0d", v));
            tick();
            chk($sformatf("vec%0d_valid_pulse", v), {31'd0, data_valid}, 32'd0);
            repeat (3) tick();
        end

        // Reset at bit 9, released while the window is still open.
        for (int i = 0; i < 9; i++) begin
            reader_en_sync = 1'b1;
            set_lanes(18'h15555, 18'h0AAAA, 18'h00007, i);
            tick();
        end
        rst = 1'b1;
        tick();
        check_zero("rst_mid");
        clear_model();
        rst = 1'b0;
        for (int i = 10; i < 18; i++) begin
            set_lanes(18'h15555, 18'h0AAAA, 18'h00007, i);
            tick();
        end
        reader_en_sync = 1'b0;
        adc_sdo        = '0;
        repeat (3) tick();
        check_zero("rst_partial");
        drive_window(18, 18'h01234, 18'h3FFFE, 18'h2AAAA, 1'b1, 1'b1);
        chk("rst_next_seq", {16'd0, frame_seq}, 32'd1);
        check_counters("rst_next");
        repeat (3) tick();

        // Backpressure over frames A, B, C.
        do_reset();
        drive_window(18, 18'h0000A, 18'h1000A, 18'h2000A, 1'b1, 1'b0);
        repeat (3) tick();
        drive_window(18, 18'h0000B, 18'h1000B, 18'h2000B, 1'b1, 1'b0);
        repeat (3) tick();
        drive_window(18, 18'h0000C, 18'h1000C, 18'h2000C, 1'b1, 1'b0);
        repeat (3) tick();
        chk("bp_overrun_cnt", {16'd0, overrun_cnt}, 32'd2);
        check_counters("bp");
        chk_frame("bp_adc_data_c", adc_data, make_frame(18'h0000C, 18'h1000C, 18'h2000C));
        data_ready = 1'b1;
        tick();
        chk("bp_frame_seq", {16'd0, frame_seq}, 32'd3);
        chk("bp_valid_after_accept", {31'd0, data_valid}, 32'd0);

        // Ready raised exactly on the commit edge of frame 2.
        do_reset();
        drive_window(18, 18'h11111, 18'h22222, 18'h33333, 1'b1, 1'b0);
        repeat (3) tick();
        drive_window(18, 18'h04444, 18'h05555, 18'h06666, 1'b1, 1'b1);
        chk("sim_valid_held", {31'd0, data_valid}, 32'd1);
        chk("sim_overrun_cnt", {16'd0, overrun_cnt}, 32'd0);
        chk_frame("sim_adc_data", adc_data, make_frame(18'h04444, 18'h05555, 18'h06666));
        tick();
        chk("sim_valid_cleared", {31'd0, data_valid}, 32'd0);
        check_counters("sim");

        // Counter limits from preloaded values.
        do_reset();
        data_ready = 1'b1;
        force dut.frame_err_cnt = 16'hFFFE;
        tick();
        release dut.frame_err_cnt;
        m_err = 16'hFFFE;
        tick();
        chk("err_preload", {16'd0, frame_err_cnt}, 32'h0000FFFE);
        drive_window(17, 18'h00001, 18'h00001, 18'h00001, 1'b0, 1'b1);
        chk("err_reach_max", {16'd0, frame_err_cnt}, 32'h0000FFFF);
        tick();
        drive_window(19, 18'h00001, 18'h00001, 18'h00001, 1'b0, 1'b1);
        chk("err_saturate", {16'd0, frame_err_cnt}, 32'h0000FFFF);
        force dut.frame_seq = 16'hFFFF;
        tick();
        release dut.frame_seq;
        m_seq = 16'hFFFF;
        tick();
        drive_window(18, 18'h3FFFF, 18'h00000, 18'h20001, 1'b1, 1'b1);
        chk("seq_wrap", {16'd0, frame_seq}, 32'd0);
        check_counters("limits");
        repeat (2) tick();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
